xor_checksum: RTL and testbench

XOR_CHECKSUM -- requirements
Module: xor_checksum

---
 rtl/xor_pkg.sv | 13 +
 rtl/xor_checksum_if.sv | 39 +++
 rtl/xor_reduce.sv | 9 +
 rtl/xor_checksum.sv | 102 ++++++++++
 tb/tb_xor_checksum.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/xor_pkg.sv
// Shared definitions for the XOR checksum block: FSM states and default widths.
package xor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

endpackage

// File: rtl/xor_checksum_if.sv
// Stream-in / result-out bus of the XOR checksum block.
// Optional macro XOR_CHECKSUM_CHECK_EN adds exp_sum (with the last beat) and err.
interface xor_checksum_if import xor_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_parity;
    logic [LEN_W-1:0]  out_len;
    logic              out_ovf;
`ifdef XOR_CHECKSUM_CHECK_EN
    logic [DATA_W-1:0] exp_sum;
    logic              err;

    modport master (
        output in_valid, in_data, in_last, out_ready, exp_sum,
        input  in_ready, out_valid, out_sum, out_parity, out_len, out_ovf, err
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready, exp_sum,
        output in_ready, out_valid, out_sum, out_parity, out_len, out_ovf, err
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_parity, out_len, out_ovf
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_parity, out_len, out_ovf
    );
`endif
endinterface

// File: rtl/xor_reduce.sv
// Width-parametrised reduction XOR (parity of a word).
module xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);
    assign parity = ^data;
endmodule

// File: rtl/xor_checksum.sv
// XOR checksum over a framed word stream: accumulates the XOR of every word
// and a saturating beat count, then holds the result until it is taken.
// Optional macro XOR_CHECKSUM_CHECK_EN adds a compare against an expected sum.
module xor_checksum import xor_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    xor_checksum_if.slave bus
);
    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    state_t            state_q;
    state_t            state_d;
    logic              ready;
    logic              accept;
    logic [DATA_W-1:0] acc;
    logic [LEN_W-1:0]  len;
    logic              ovf;
    logic              parity;

    assign accept = bus.in_valid && ready;

    // State register; reset drops any partial frame back to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; HOLD blocks input until the result is taken.
    always_comb begin
        state_d = state_q;
        ready   = rst_n;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_d = bus.in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                ready = 1'b0;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator and beat counter; the first beat of a frame reloads both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            len <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                acc <= bus.in_data;
                len <= LEN_W'(1);
                ovf <= 1'b0;
            end else begin
                acc <= acc ^ bus.in_data;
                if (len == LEN_MAX) begin
                    ovf <= 1'b1;
                end else begin
                    len <= len + 1'b1;
                end
            end
        end
    end

    xor_reduce #(.WIDTH(DATA_W)) u_parity (
        .data   (acc),
        .parity (parity)
    );

    assign bus.in_ready   = ready;
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_sum    = acc;
    assign bus.out_parity = parity;
    assign bus.out_len    = len;
    assign bus.out_ovf    = ovf;

`ifdef XOR_CHECKSUM_CHECK_EN
    logic [DATA_W-1:0] exp_q;

    // Capture the expected sum alongside the closing beat of the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q <= '0;
        end else if (accept && bus.in_last) begin
            exp_q <= bus.exp_sum;
        end
    end

    assign bus.err = (state_q == HOLD) && (acc != exp_q);
`endif
endmodule

// File: tb/tb_xor_checksum.sv
// Directed self-checking bench for xor_checksum (DATA_W=8, LEN_W=4).
module tb_xor_checksum;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    xor_checksum_if #(.DATA_W(8), .LEN_W(4)) bus ();

    xor_checksum #(.DATA_W(8), .LEN_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one edge, then scramble the idle inputs.
    task automatic send_beat(input logic [7:0] data, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'($urandom);
    endtask

    task automatic take_result(input string name);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL %s_release out_valid got %b want 0", name, bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL %s_release in_ready got %b want 1", name, bus.in_ready); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.out_sum !== 8'h00) begin failures++; $display("FAIL reset_out_sum got %h want 00", bus.out_sum); end
        checks++; if (bus.out_parity !== 1'b0) begin failures++; $display("FAIL reset_out_parity got %b want 0", bus.out_parity); end
        checks++; if (bus.out_len !== 4'd0) begin failures++; $display("FAIL reset_out_len got %0d want 0", bus.out_len); end
        checks++; if (bus.out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got %b want 0", bus.out_ovf); end
        rst_n = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single();
        send_beat(8'hA5, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 8'hA5) begin failures++; $display("FAIL single_out_sum got %h want a5", bus.out_sum); end
        checks++; if (bus.out_parity !== 1'b0) begin failures++; $display("FAIL single_out_parity got %b want 0", bus.out_parity); end
        checks++; if (bus.out_len !== 4'd1) begin failures++; $display("FAIL single_out_len got %0d want 1", bus.out_len); end
        take_result("single");
    endtask

    task automatic test_gaps();
        send_beat(8'h0F, 1'b0);
        step(); step();
        send_beat(8'hF0, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL gaps_mid_out_valid got %b want 0", bus.out_valid); end
        step(); step(); step();
        send_beat(8'hFF, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL gaps_out_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 8'h00) begin failures++; $display("FAIL gaps_out_sum got %h want 00", bus.out_sum); end
        checks++; if (bus.out_parity !== 1'b0) begin failures++; $display("FAIL gaps_out_parity got %b want 0", bus.out_parity); end
        checks++; if (bus.out_len !== 4'd3) begin failures++; $display("FAIL gaps_out_len got %0d want 3", bus.out_len); end
        take_result("gaps");
    endtask

    // Frame 0x12,0x34 -> 0x26 (three ones, parity 1); stall with in_valid asserted.
    task automatic test_hold();
        send_beat(8'h12, 1'b0);
        send_beat(8'h34, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid cycle %0d got %b want 1", i, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cycle %0d got %b want 0", i, bus.in_ready); end
            checks++; if (bus.out_sum !== 8'h26) begin failures++; $display("FAIL hold_out_sum cycle %0d got %h want 26", i, bus.out_sum); end
            checks++; if (bus.out_parity !== 1'b1) begin failures++; $display("FAIL hold_out_parity cycle %0d got %b want 1", i, bus.out_parity); end
            checks++; if (bus.out_len !== 4'd2) begin failures++; $display("FAIL hold_out_len cycle %0d got %0d want 2", i, bus.out_len); end
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_sum !== 8'h26) begin failures++; $display("FAIL hold_release_no_accept out_sum got %h want 26", bus.out_sum); end
        send_beat(8'h11, 1'b1);
        checks++; if (bus.out_sum !== 8'h11) begin failures++; $display("FAIL hold_next_out_sum got %h want 11", bus.out_sum); end
        checks++; if (bus.out_len !== 4'd1) begin failures++; $display("FAIL hold_next_out_len got %0d want 1", bus.out_len); end
        take_result("hold");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) begin
            send_beat(8'h01, (i == 19));
        end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ovf_out_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_len !== 4'd15) begin failures++; $display("FAIL ovf_out_len got %0d want 15", bus.out_len); end
        checks++; if (bus.out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_out_ovf got %b want 1", bus.out_ovf); end
        checks++; if (bus.out_sum !== 8'h00) begin failures++; $display("FAIL ovf_out_sum got %h want 00", bus.out_sum); end
        take_result("ovf");
        send_beat(8'h01, 1'b1);
        checks++; if (bus.out_ovf !== 1'b0) begin failures++; $display("FAIL ovf_next_out_ovf got %b want 0", bus.out_ovf); end
        checks++; if (bus.out_len !== 4'd1) begin failures++; $display("FAIL ovf_next_out_len got %0d want 1", bus.out_len); end
        take_result("ovf_next");
    endtask

    task automatic test_mid_reset();
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        rst_n = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_len !== 4'd0) begin failures++; $display("FAIL midrst_out_len got %0d want 0", bus.out_len); end
        rst_n = 1'b1;
        step();
        send_beat(8'h3C, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL midrst_next_out_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 8'h3C) begin failures++; $display("FAIL midrst_next_out_sum got %h want 3c", bus.out_sum); end
        checks++; if (bus.out_len !== 4'd1) begin failures++; $display("FAIL midrst_next_out_len got %0d want 1", bus.out_len); end
        take_result("midrst");
    endtask

`ifdef XOR_CHECKSUM_CHECK_EN
    task automatic test_check();
        bus.exp_sum = 8'h5A;
        send_beat(8'h50, 1'b0);
        send_beat(8'h0A, 1'b1);
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL check_match err got %b want 0", bus.err); end
        take_result("check_match");
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL check_idle err got %b want 0", bus.err); end
        bus.exp_sum = 8'h5B;
        send_beat(8'h50, 1'b0);
        send_beat(8'h0A, 1'b1);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL check_mismatch err got %b want 1", bus.err); end
        take_result("check_mismatch");
    endtask
`endif

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
`ifdef XOR_CHECKSUM_CHECK_EN
        bus.exp_sum   = 8'h00;
`endif
        test_reset();
        test_single();
        test_gaps();
        test_hold();
        test_overflow();
        test_mid_reset();
`ifdef XOR_CHECKSUM_CHECK_EN
        test_check();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
